// File: rtl/dw_add_serial_if.sv
// Handshake bundle for the digit-serial adder: operand side (a, b, ci) and result side (sum, co).
// The master drives operands and consumes results; the slave is the adder.
interface dw_add_serial_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             co;
   logic             busy;

   modport master (
      output in_valid, a, b, ci, out_ready,
      input  in_ready, out_valid, sum, co, busy
   );

   modport slave (
      input  in_valid, a, b, ci, out_ready,
      output in_ready, out_valid, sum, co, busy
   );
endinterface

// File: rtl/dw_add_serial.sv
// Digit-serial adder: sum = a + b + ci, DIGIT bits per clock with a registered carry.
// One operation in flight; result is held in DONE until the consumer takes it.
module dw_add_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input logic             clk,
   input logic             rst_n,
   dw_add_serial_if.slave  bus
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               carry;
   logic               in_ready_r;
   logic               out_valid_r;
   logic               busy_r;
   logic [WIDTH-1:0]   sum_r;
   logic               co_r;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [WIDTH-1:0]   res;
   logic [WIDTH-1:0]   res_nxt;
   logic [DIGIT:0]     dsum;
   int                 idx;

   function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                                input logic [DIGIT-1:0] y,
                                                input logic             c);
      return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, c};
   endfunction

   assign dsum = digit_add(a_sh[DIGIT-1:0], b_sh[DIGIT-1:0], carry);
   assign idx  = int'(cnt) * DIGIT;

   // Result register with the current digit merged in at its slot.
   always_comb begin
      res_nxt = res;
      res_nxt[idx +: DIGIT] = dsum[DIGIT-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         carry       <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         sum_r       <= '0;
         co_r        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  state      <= RUN;
                  carry      <= bus.ci;
                  cnt        <= '0;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
               end
            end
            RUN: begin
               carry <= dsum[DIGIT];
               cnt   <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(N - 1)) begin
                  state       <= DONE;
                  cnt         <= '0;
                  sum_r       <= res_nxt;
                  co_r        <= dsum[DIGIT];
                  out_valid_r <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  busy_r      <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   // Operand shifters and partial result carry no reset; they are rewritten at every accept.
   always_ff @(posedge clk) begin
      if (state == IDLE && bus.in_valid) begin
         a_sh <= bus.a;
         b_sh <= bus.b;
      end else if (state == RUN) begin
         a_sh <= a_sh >> DIGIT;
         b_sh <= b_sh >> DIGIT;
         res  <= res_nxt;
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.sum       = sum_r;
   assign bus.co        = co_r;

endmodule
